// File: rtl/icache_refill.sv
// Instruction-cache line refill: one line-aligned read request, BEATS data beats, one-cycle line write.
// Optional RECV watchdog is compiled in when ICACHE_REFILL_TIMEOUT_EN is defined.
module icache_refill #(
   parameter int BLOCK_WIDTH    = 512,
   parameter int ADDR_WIDTH     = 64,
   parameter int BUS_WIDTH      = 64,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                   clk,
   input  logic                   arstn,
   input  logic                   i_miss,
   input  logic [ADDR_WIDTH-1:0]  i_miss_addr,
   output logic                   o_busy,
   output logic                   o_mem_req_valid,
   input  logic                   i_mem_req_ready,
   output logic [ADDR_WIDTH-1:0]  o_mem_addr,
   input  logic                   i_mem_rvalid,
   input  logic [BUS_WIDTH-1:0]   i_mem_rdata,
   input  logic                   i_mem_rerr,
   output logic                   o_cache_we,
   output logic [ADDR_WIDTH-1:0]  o_cache_addr,
   output logic [BLOCK_WIDTH-1:0] o_cache_line,
   output logic                   o_refill_done,
   output logic                   o_refill_err,
   output logic [1:0]             o_dbg_state
);

   localparam int BEATS = BLOCK_WIDTH / BUS_WIDTH;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   // Request handshake: o_mem_req_valid and o_mem_addr stay constant until the
   // cycle i_mem_req_ready is high; the request is transferred on that edge.
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RECV, S_WRITE} state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic [ADDR_WIDTH-1:0]  r_addr;
   logic [ADDR_WIDTH-1:0]  r_line_addr;
   logic [BLOCK_WIDTH-1:0] r_line;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_err;
   logic                   r_err_pulse;
   logic [ADDR_WIDTH-1:0]  w_miss_line;
   logic                   w_accept;
   logic                   w_beat;
   logic                   w_last;
   logic                   w_abort;
   logic                   w_timeout;

   assign w_miss_line = i_miss_addr & ~ADDR_WIDTH'(BLOCK_WIDTH / 8 - 1);
   assign w_accept    = (r_state == S_IDLE) && i_miss;
   assign w_beat      = (r_state == S_RECV) && i_mem_rvalid;
   assign w_last      = (r_cnt == CNT_W'(BEATS - 1));
   assign w_abort     = (w_beat && w_last && (r_err || i_mem_rerr)) || w_timeout;

`ifdef ICACHE_REFILL_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] r_wdog;

   assign w_timeout = (r_state == S_RECV) && !i_mem_rvalid &&
                      (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));

   // Counts consecutive beat-less RECV cycles; held at zero outside RECV.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn)
         r_wdog <= '0;
      else if ((r_state != S_RECV) || i_mem_rvalid || w_timeout)
         r_wdog <= '0;
      else
         r_wdog <= r_wdog + 1'b1;
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_miss) w_next = S_REQ;
         S_REQ:   if (i_mem_req_ready) w_next = S_RECV;
         S_RECV: begin
            if (w_abort)
               w_next = S_IDLE;
            else if (w_beat && w_last)
               w_next = S_WRITE;
         end
         S_WRITE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         r_addr      <= '0;
         r_line_addr <= '0;
         r_line      <= '0;
         r_cnt       <= '0;
         r_err       <= 1'b0;
         r_err_pulse <= 1'b0;
      end else begin
         r_err_pulse <= w_abort;
         if (w_accept) begin
            r_addr <= w_miss_line;
            r_cnt  <= '0;
            r_err  <= 1'b0;
         end else if (w_timeout) begin
            r_cnt <= '0;
            r_err <= 1'b0;
         end else if (w_beat) begin
            r_line[r_cnt*BUS_WIDTH +: BUS_WIDTH] <= i_mem_rdata;
            // The cache-side address follows the new line only once its data starts arriving.
            if (r_cnt == '0)
               r_line_addr <= r_addr;
            if (w_last) begin
               r_cnt <= '0;
               r_err <= 1'b0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
               r_err <= r_err | i_mem_rerr;
            end
         end
      end
   end

   assign o_busy          = (r_state != S_IDLE);
   assign o_mem_req_valid = (r_state == S_REQ);
   assign o_mem_addr      = r_addr;
   assign o_cache_we      = (r_state == S_WRITE);
   assign o_refill_done   = (r_state == S_WRITE);
   assign o_cache_addr    = r_line_addr;
   assign o_cache_line    = r_line;
   assign o_refill_err    = r_err_pulse;
   assign o_dbg_state     = r_state;

endmodule
